// File: rtl/cache_mem_tester_pkg.sv
// Shared types for the cache traffic generator: FSM states, write-enable codes
// and the address-derived data pattern that both writer and checker agree on.
package cache_mem_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_DONE
    } tester_state_t;

    localparam logic [3:0] WRITE_ALL = 4'b1111;
    localparam logic [3:0] READ      = 4'b0000;

    function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/access_timeout.sv
// Per-access watchdog: loadable down-counter, expiry once it has run down to zero.
// Load/clear take effect on the next edge; expiry is masked while a reload is pending.
module access_timeout #(
    parameter int unsigned LOAD_VALUE = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (LOAD_VALUE > 0) ? $clog2(LOAD_VALUE + 1) : 1;

    logic [CW-1:0] count;
    logic          armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            armed <= 1'b0;
        end else if (clear) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= CW'(LOAD_VALUE);
            armed <= 1'b1;
        end else if (armed && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // A leftover count from the previous access must not fire before the reload lands.
    assign expired = armed && (count == '0) && !load;

endmodule

// File: rtl/cache_mem_tester.sv
// Writes addr^SEED to WORD_COUNT words through the cache CPU port, reads back and checks.
// Two cycles per access when the cache never stalls; waits on busy/data_out_ready, aborts on timeout.
module cache_mem_tester
    import cache_mem_tester_pkg::*;
#(
    parameter logic [31:0] ADDR_START     = 32'h0000_0000,
    parameter int unsigned WORD_COUNT     = 64,
    parameter logic [31:0] SEED           = 32'h1234_5678,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] address,
    output logic [31:0] data_in,
    output logic [3:0]  write_enable,
    input  logic [31:0] data_out,
    input  logic        data_out_ready,
    input  logic        busy,
    output logic        running,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] error_count,
    output logic [31:0] first_error_addr
);

    localparam int unsigned IDX_W    = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);
    localparam int unsigned TMO_LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    tester_state_t    state;
    logic [IDX_W-1:0] word_idx;
    logic             tmo_load;
    logic             tmo_clear;
    logic             tmo_expired;
    logic             rd_mismatch;
    logic             last_word;
    logic [15:0]      error_count_inc;

    access_timeout #(
        .LOAD_VALUE(TMO_LOAD)
    ) u_access_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (tmo_load),
        .clear  (tmo_clear),
        .expired(tmo_expired)
    );

    assign rd_mismatch     = (data_out != pattern(address, SEED));
    assign last_word       = (word_idx == LAST_IDX);
    assign error_count_inc = (error_count == 16'hFFFF) ? error_count : error_count + 16'd1;

    // The counter is reloaded one edge after the FSM enters an issue state, so it is
    // loaded with TIMEOUT_CYCLES-1 to keep the abort at TIMEOUT_CYCLES+1 cycles after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            word_idx         <= '0;
            address          <= '0;
            data_in          <= '0;
            write_enable     <= READ;
            running          <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            error_count      <= '0;
            first_error_addr <= '0;
            tmo_load         <= 1'b0;
            tmo_clear        <= 1'b0;
        end else begin
            tmo_load  <= 1'b0;
            tmo_clear <= 1'b0;

            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state            <= ST_WR_ISSUE;
                        word_idx         <= '0;
                        address          <= ADDR_START;
                        write_enable     <= READ;
                        running          <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        timeout          <= 1'b0;
                        error_count      <= '0;
                        first_error_addr <= '0;
                        tmo_load         <= 1'b1;
                    end
                end

                ST_WR_ISSUE: begin
                    if (tmo_expired) begin
                        state        <= ST_DONE;
                        write_enable <= READ;
                        running      <= 1'b0;
                        done         <= 1'b1;
                        pass         <= 1'b0;
                        timeout      <= 1'b1;
                        tmo_clear    <= 1'b1;
                    end else if (!busy) begin
                        state        <= ST_WR_WAIT;
                        data_in      <= pattern(address, SEED);
                        write_enable <= WRITE_ALL;
                    end
                end

                // busy is first sampled at the end of the cycle the write strobe is on the bus.
                ST_WR_WAIT: begin
                    write_enable <= READ;
                    if (tmo_expired) begin
                        state     <= ST_DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout   <= 1'b1;
                        tmo_clear <= 1'b1;
                    end else if (!busy) begin
                        tmo_load <= 1'b1;
                        if (last_word) begin
                            state    <= ST_RD_ISSUE;
                            address  <= ADDR_START;
                            word_idx <= '0;
                        end else begin
                            state    <= ST_WR_ISSUE;
                            address  <= address + 32'd4;
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                end

                ST_RD_ISSUE: begin
                    write_enable <= READ;
                    if (tmo_expired) begin
                        state     <= ST_DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout   <= 1'b1;
                        tmo_clear <= 1'b1;
                    end else if (!busy) begin
                        state <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    write_enable <= READ;
                    if (tmo_expired) begin
                        state     <= ST_DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout   <= 1'b1;
                        tmo_clear <= 1'b1;
                    end else if (data_out_ready && !busy) begin
                        if (rd_mismatch) begin
                            error_count <= error_count_inc;
                            if (error_count == '0) begin
                                first_error_addr <= address;
                            end
                        end
                        if (last_word) begin
                            state     <= ST_DONE;
                            running   <= 1'b0;
                            done      <= 1'b1;
                            pass      <= !rd_mismatch && (error_count == '0) && !timeout;
                            tmo_clear <= 1'b1;
                        end else begin
                            state    <= ST_RD_ISSUE;
                            address  <= address + 32'd4;
                            word_idx <= word_idx + IDX_W'(1);
                            tmo_load <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    write_enable <= READ;
                    running      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_tester.sv
module tb_cache_mem_tester;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_enable;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        running;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] error_count;
    logic [31:0] first_error_addr;

    // second instance: short watchdog, cache permanently busy
    logic        t_start;
    logic        t_busy;
    logic [31:0] t_address;
    logic [31:0] t_data_in;
    logic [3:0]  t_write_enable;
    logic        t_running;
    logic        t_done;
    logic        t_pass;
    logic        t_timeout;
    logic [15:0] t_error_count;
    logic [31:0] t_first_error_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_mem_tester #(
        .ADDR_START(32'h0000_0000), .WORD_COUNT(4), .SEED(32'h1234_5678), .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .address(address), .data_in(data_in), .write_enable(write_enable),
        .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
        .running(running), .done(done), .pass(pass), .timeout(timeout),
        .error_count(error_count), .first_error_addr(first_error_addr)
    );

    cache_mem_tester #(
        .ADDR_START(32'h0000_0000), .WORD_COUNT(4), .SEED(32'h1234_5678), .TIMEOUT_CYCLES(16)
    ) dut_t (
        .clk(clk), .rst(rst), .start(t_start),
        .address(t_address), .data_in(t_data_in), .write_enable(t_write_enable),
        .data_out(32'h0), .data_out_ready(1'b0), .busy(t_busy),
        .running(t_running), .done(t_done), .pass(t_pass), .timeout(t_timeout),
        .error_count(t_error_count), .first_error_addr(t_first_error_addr)
    );

    // cache model: writes land in mem, read data/ready registered one cycle after address
    logic        model_clr;
    logic        corrupt;
    logic        evict;
    logic [31:0] mem [16];
    logic [31:0] wr_addr_log [8];
    logic [31:0] wr_data_log [8];
    int          wr_pulses;
    int          acc_events;
    int          busy_events;
    int          busy_cnt;
    logic        rd_mode;
    logic        have_rd;
    logic [31:0] last_rd;
    logic        m_ev;

    always_comb begin
        m_ev = 1'b0;
        if (write_enable == 4'hF)
            m_ev = 1'b1;
        else if (rd_mode && write_enable == 4'h0 && !busy && (!have_rd || address != last_rd))
            m_ev = 1'b1;
    end

    always @(posedge clk) begin
        if (model_clr) begin
            wr_pulses      <= 0;
            acc_events     <= 0;
            busy_events    <= 0;
            busy_cnt       <= 0;
            busy           <= 1'b0;
            data_out_ready <= 1'b0;
            data_out       <= 32'h0;
            rd_mode        <= 1'b0;
            have_rd        <= 1'b0;
            last_rd        <= 32'h0;
        end else begin
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                busy     <= (busy_cnt > 1);
            end
            if (write_enable != 4'h0) begin
                mem[address[5:2]]           <= data_in;
                wr_addr_log[wr_pulses % 8]  <= address;
                wr_data_log[wr_pulses % 8]  <= data_in;
                wr_pulses                   <= wr_pulses + 1;
                if (wr_pulses + 1 == 4) rd_mode <= 1'b1;
            end else if (!busy) begin
                data_out       <= mem[address[5:2]] ^ {31'h0, (corrupt && address == 32'h8)};
                data_out_ready <= rd_mode;
            end
            if (m_ev) begin
                acc_events <= acc_events + 1;
                if (write_enable == 4'h0) begin
                    have_rd <= 1'b1;
                    last_rd <= address;
                end
                if (evict && ((acc_events + 1) % 4 == 0)) begin
                    busy        <= 1'b1;
                    busy_cnt    <= 20;
                    busy_events <= busy_events + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model();
        tick();
        total++; if (write_enable !== 4'h0) begin bad++; $display("FAIL reset_we got=%h want=0", write_enable); end
        total++; if (address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", address); end
        total++; if ({running, done, pass, timeout} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {running, done, pass, timeout}); end
        total++; if (error_count !== 16'h0 || first_error_addr !== 32'h0) begin bad++; $display("FAIL reset_err got=%h/%h want=0/0", error_count, first_error_addr); end
        rst = 1'b0;
        tick();
        tick();
        total++; if ({running, done, data_in} !== 34'h0) begin bad++; $display("FAIL idle_no_start got=%b/%b/%h want=0", running, done, data_in); end
    endtask

    task automatic test_ideal();
        int cycles;
        clear_model();
        pulse_start();
        total++; if (running !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ideal_running got=%b done=%b want=1/0", running, done); end
        wait_done(200, cycles);
        total++; if (cycles !== 16) begin bad++; $display("FAIL ideal_latency got=%0d want=16", cycles); end
        total++; if ({done, pass, running, timeout} !== 4'b1100 || error_count !== 16'h0) begin bad++; $display("FAIL ideal_result got=%b err=%0d want=1100 err=0", {done, pass, running, timeout}, error_count); end
        total++; if (wr_pulses !== 4) begin bad++; $display("FAIL ideal_wr_pulses got=%0d want=4", wr_pulses); end
        total++; if (wr_addr_log[0] !== 32'h0 || wr_addr_log[1] !== 32'h4 || wr_addr_log[2] !== 32'h8 || wr_addr_log[3] !== 32'hC) begin
            bad++; $display("FAIL ideal_wr_addr got=%h %h %h %h want=0 4 8 c", wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3]);
        end
        total++; if (wr_data_log[0] !== 32'h1234_5678 || wr_data_log[1] !== 32'h1234_567C || wr_data_log[2] !== 32'h1234_5670 || wr_data_log[3] !== 32'h1234_5674) begin
            bad++; $display("FAIL ideal_wr_data got=%h %h %h %h want=12345678 1234567c 12345670 12345674", wr_data_log[0], wr_data_log[1], wr_data_log[2], wr_data_log[3]);
        end
        tick();
        tick();
        total++; if (done !== 1'b1 || pass !== 1'b1 || write_enable !== 4'h0) begin bad++; $display("FAIL ideal_hold got=%b/%b/%h want=1/1/0", done, pass, write_enable); end
    endtask

    task automatic test_corrupt();
        int cycles;
        corrupt = 1'b1;
        clear_model();
        pulse_start();
        total++; if (done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL corrupt_restart got=%b/%b want=0/0", done, pass); end
        wait_done(200, cycles);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL corrupt_done got=%b want=1 after %0d", done, cycles); end
        total++; if (error_count !== 16'd1 || first_error_addr !== 32'h8 || pass !== 1'b0) begin
            bad++; $display("FAIL corrupt_result got=err %0d addr %h pass %b want=1 8 0", error_count, first_error_addr, pass);
        end
        corrupt = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cycles;
        clear_model();
        pulse_start();
        total++; if (error_count !== 16'h0 || first_error_addr !== 32'h0) begin bad++; $display("FAIL b2b_cleared got=%h/%h want=0/0", error_count, first_error_addr); end
        wait_done(200, cycles);
        total++; if (cycles !== 16 || pass !== 1'b1 || error_count !== 16'h0) begin bad++; $display("FAIL b2b_result got=cyc %0d pass %b err %0d want=16 1 0", cycles, pass, error_count); end
    endtask

    task automatic test_evict();
        int cycles;
        evict = 1'b1;
        clear_model();
        pulse_start();
        wait_done(400, cycles);
        total++; if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL evict_result got=%b/%b/%b want=1/1/0 after %0d", done, pass, timeout, cycles); end
        total++; if (wr_pulses !== 4) begin bad++; $display("FAIL evict_wr_pulses got=%0d want=4", wr_pulses); end
        total++; if (busy_events !== 2 || cycles < 56) begin bad++; $display("FAIL evict_stalls got=ev %0d cyc %0d want=2 >=56", busy_events, cycles); end
        total++; if (mem[2] !== 32'h1234_5670 || mem[3] !== 32'h1234_5674) begin bad++; $display("FAIL evict_mem got=%h %h want=12345670 12345674", mem[2], mem[3]); end
        evict = 1'b0;
    endtask

    task automatic test_timeout();
        int cycles;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        cycles = 0;
        while (cycles < 40 && !t_done) begin
            tick();
            cycles++;
        end
        total++; if (cycles !== 17) begin bad++; $display("FAIL timeout_latency got=%0d want=17", cycles); end
        total++; if ({t_done, t_timeout, t_pass, t_running} !== 4'b1100) begin bad++; $display("FAIL timeout_flags got=%b want=1100", {t_done, t_timeout, t_pass, t_running}); end
        total++; if (t_write_enable !== 4'h0) begin bad++; $display("FAIL timeout_we got=%h want=0", t_write_enable); end
    endtask

    task automatic test_reset_mid();
        int cycles;
        clear_model();
        pulse_start();
        for (int i = 0; i < 13; i++) tick();
        total++; if (address !== 32'h8 || running !== 1'b1) begin bad++; $display("FAIL mid_position got=%h/%b want=8/1", address, running); end
        rst = 1'b1;
        #1;
        total++; if ({address, data_in, write_enable, running, done, pass, timeout, error_count, first_error_addr} !== 120'h0) begin
            bad++; $display("FAIL mid_reset_outputs got=%h %h %h %b%b%b%b %h %h want=0", address, data_in, write_enable, running, done, pass, timeout, error_count, first_error_addr);
        end
        tick();
        rst = 1'b0;
        clear_model();
        pulse_start();
        wait_done(200, cycles);
        total++; if (cycles !== 16 || pass !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL mid_restart got=cyc %0d pass %b done %b want=16 1 1", cycles, pass, done); end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        t_start   = 1'b0;
        t_busy    = 1'b1;
        model_clr = 1'b1;
        corrupt   = 1'b0;
        evict     = 1'b0;
        test_reset();
        test_ideal();
        test_corrupt();
        test_back_to_back();
        test_evict();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_tester.md
# cache_mem_tester

Self-checking traffic generator that sits directly upstream of the cache, on the cache's CPU-side port (address / data_in / write_enable / data_out / data_out_ready / busy). On `start`, it writes a deterministic pattern to a range of 32-bit words, then reads every word back and compares. It reports done/pass, an error count and the first failing address, for display on LEDs or readout over a debug path. It replaces the hand-written test FSM in the top level and exercises cache hit, miss and eviction paths against the burst RAM.

## Interface
- `ADDR_START`, 32'h0000_0000: byte address of first word; must be 4-byte aligned.
- `WORD_COUNT`, 64: number of 32-bit words tested, ≥1.
- `SEED`, 32'h1234_5678: pattern seed; expected word = `addr ^ SEED`.
- `TIMEOUT_CYCLES`, 4096: maximum cycles per access before abort.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a test; honoured only in IDLE or DONE.
- `address`  out  32  to cache `address`.
- `data_in`  out  32  to cache `data_in`.
- `write_enable`  out  4  to cache `write_enable`; 4'b1111 = write, 0 = read.
- `data_out`  in  32  from cache.
- `data_out_ready`  in  1  from cache; `data_out` is valid for the current `address`.
- `busy`  in  1  from cache; access in progress (miss fill or eviction).
- `running`  out  1  test in progress.
- `done`  out  1  test finished; held until next `start` or reset.
- `pass`  out  1  valid when `done`; 1 = zero errors and no timeout.
- `timeout`  out  1  valid when `done`; an access exceeded `TIMEOUT_CYCLES`.
- `error_count`  out  16  mismatches, saturating at 16'hFFFF.
- `first_error_addr`  out  32  address of first mismatch; 0 if none.

## Operation
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE.
- IDLE/DONE + `start`:
  - Clear `error_count`, `first_error_addr` and `timeout`.
  - Set `address` = `ADDR_START` and word index = 0.
  - Go to WR_ISSUE.
- WR_ISSUE:
  - Waits while `busy`=1.
  - When `busy`=0: drive `data_in` = `address ^ SEED` and `write_enable` = 4'b1111 for exactly one cycle, then go to WR_WAIT.
- WR_WAIT:
  - `write_enable` = 0; `address` and `data_in` are held.
  - Exits when `busy`=0, sampled no earlier than the 2nd cycle after issue.
  - If the index is not the last: `address` += 4, back to WR_ISSUE.
  - If the index is the last: `address` = `ADDR_START`, go to RD_ISSUE.
- RD_ISSUE:
  - `write_enable` = 0.
  - When `busy`=0, go to RD_WAIT.
- RD_WAIT:
  - Waits for `data_out_ready`=1 and `busy`=0 in the same cycle.
  - Compares `data_out` with `address ^ SEED`.
  - On mismatch: increment `error_count` (saturating). If this is the first error, capture `first_error_addr`.
  - If the index is not the last: `address` += 4, RD_ISSUE. If the index is the last: DONE.
- Timeout: a per-access counter clears on entry to each ISSUE state. If it reaches `TIMEOUT_CYCLES`, set `timeout`, go to DONE, drive `write_enable` = 0.
- `pass` = (`error_count` == 0) && !`timeout`, registered on entry to DONE.
- Address arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC is permitted and not flagged.
- `start` while `running` is ignored.

## Timing
- Reset values: every output is 0; state IDLE.
- Reset mid-test aborts immediately; `write_enable` is 0 in the same cycle reset asserts.
- All outputs are registered; no combinational path from inputs to outputs.
- `running` goes high the cycle after `start` is sampled and falls the same cycle `done` rises.
- Minimum latency per write, with `busy` never asserted: 2 cycles (ISSUE + WAIT).
- Minimum latency per read, with an immediate ready: 2 cycles.
- Minimum total time: 4·`WORD_COUNT` cycles from `start` to `done`.
- `write_enable` is nonzero for exactly one cycle per word.

## Structure
- Shared package holds:
  - the state enum;
  - the `WRITE_ALL` = 4'b1111 / `READ` = 4'b0000 constants;
  - a `pattern(addr, seed)` function, reused by the bench scoreboard.
- One natural sub-module: `access_timeout`, a loadable down-counter with a clear input and an expiry flag.
- Top level: instantiate between the reset/button logic and `cache`. Map `{busy, done, pass, timeout, running}` to LEDs.

## Test plan
- Ideal cache model (never busy, ready 1 cycle after read), `WORD_COUNT`=4, `start` pulse
  - → 4 writes of `addr ^ 32'h1234_5678` to 0x0, 0x4, 0x8, 0xC;
  - → `done`=1, `pass`=1, `error_count`=0 after exactly 16 cycles.
- Model corrupts the read at 0x8 (bit 0 flipped)
  - → `error_count`=1, `first_error_addr`=0x8, `pass`=0.
- Model asserts `busy` for 20 cycles after every 4th access (eviction)
  - → no extra `write_enable` pulses, `pass`=1, one write pulse per word.
- `busy` stuck high, `TIMEOUT_CYCLES`=16
  - → `done`=1, `timeout`=1, `pass`=0 within 17 cycles of `start`.
- Async reset asserted during RD_WAIT of word 2
  - → all outputs 0 on the same edge, state IDLE.
  - Then a fresh `start` completes with `pass`=1.
- Real cache plus burst RAM, `WORD_COUNT`=2048 (exceeds cache capacity)
  - → `pass`=1; a second `start` without reset also gives `pass`=1 with cleared counters.
